// File: rtl/conv2d_sched.sv
// conv2d_sched: round-robin job scheduler for one shared conv2d engine.
// Grants one requester, launches the engine, relocates engine-local addresses
// into the shared memory map while the job runs, and reports done or timeout.
module conv2d_sched #(
    parameter int unsigned NREQ    = 2,
    parameter int unsigned AW      = 16,
    parameter int unsigned TIMEOUT = 2048
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic [NREQ-1:0]            req_valid_i,
    output logic [NREQ-1:0]            req_ready_o,
    input  logic [NREQ*AW-1:0]         req_wbase_i,
    input  logic [NREQ*AW-1:0]         req_fbase_i,
    input  logic [NREQ*AW-1:0]         req_obase_i,
    output logic                       eng_start_o,
    output logic                       eng_abort_o,
    input  logic                       eng_done_i,
    input  logic [AW-1:0]              eng_raddr_i,
    input  logic                       eng_is_weight_i,
    input  logic [AW-1:0]              eng_waddr_i,
    input  logic                       eng_wen_i,
    output logic [AW-1:0]              mem_raddr_o,
    output logic [AW-1:0]              mem_waddr_o,
    output logic                       mem_wen_o,
    output logic                       resp_valid_o,
    output logic [$clog2(NREQ)-1:0]    resp_id_o,
    output logic                       resp_err_o,
    output logic                       busy_o
);

    localparam int unsigned IDW = $clog2(NREQ);
    localparam int unsigned WDW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_RUN    = 2'd2,
        S_RESP   = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [IDW-1:0]  rr_q, rr_d;
    logic [IDW-1:0]  id_q, id_d;
    logic            err_q, err_d;
    logic [WDW-1:0]  wdog_q, wdog_d;
    logic [AW-1:0]   wbase_q, wbase_d;
    logic [AW-1:0]   fbase_q, fbase_d;
    logic [AW-1:0]   obase_q, obase_d;

    logic [AW-1:0]   wb_a [NREQ];
    logic [AW-1:0]   fb_a [NREQ];
    logic [AW-1:0]   ob_a [NREQ];

    logic            grant_vld_c;
    logic [IDW-1:0]  grant_id_c;
    logic [IDW-1:0]  cand_c;

    logic [NREQ-1:0] ready_c;
    logic            start_c;
    logic            abort_c;
    logic            resp_c;
    logic [AW-1:0]   raddr_c;
    logic [AW-1:0]   waddr_c;
    logic            wen_c;

    // Split the flat descriptor buses into per-requester views.
    for (genvar g = 0; g < int'(NREQ); g++) begin : g_desc
        assign wb_a[g] = req_wbase_i[g*AW +: AW];
        assign fb_a[g] = req_fbase_i[g*AW +: AW];
        assign ob_a[g] = req_obase_i[g*AW +: AW];
    end

    // Round-robin pick: first valid index at or after rr_q, wrapping.
    always_comb begin
        grant_vld_c = 1'b0;
        grant_id_c  = '0;
        cand_c      = '0;
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
            if (int'(rr_q) + i >= int'(NREQ)) begin
                cand_c = IDW'(int'(rr_q) + i - int'(NREQ));
            end else begin
                cand_c = IDW'(int'(rr_q) + i);
            end
            if (req_valid_i[cand_c]) begin
                grant_vld_c = 1'b1;
                grant_id_c  = cand_c;
            end
        end
    end

    // State and job context registers.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q <= S_IDLE;
            rr_q    <= '0;
            id_q    <= '0;
            err_q   <= 1'b0;
            wdog_q  <= '0;
            wbase_q <= '0;
            fbase_q <= '0;
            obase_q <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            id_q    <= id_d;
            err_q   <= err_d;
            wdog_q  <= wdog_d;
            wbase_q <= wbase_d;
            fbase_q <= fbase_d;
            obase_q <= obase_d;
        end
    end

    // Next-state and control decode for the job lifecycle.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        id_d    = id_q;
        err_d   = err_q;
        wdog_d  = wdog_q;
        wbase_d = wbase_q;
        fbase_d = fbase_q;
        obase_d = obase_q;
        ready_c = '0;
        start_c = 1'b0;
        abort_c = 1'b0;
        resp_c  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (grant_vld_c) begin
                    ready_c[grant_id_c] = 1'b1;
                    id_d    = grant_id_c;
                    wbase_d = wb_a[grant_id_c];
                    fbase_d = fb_a[grant_id_c];
                    obase_d = ob_a[grant_id_c];
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                start_c = 1'b1;
                wdog_d  = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                wdog_d = wdog_q + WDW'(1);
                // Done takes priority over a coincident timeout.
                if (eng_done_i) begin
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (wdog_q == WDW'(TIMEOUT - 1)) begin
                    abort_c = 1'b1;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                resp_c  = 1'b1;
                rr_d    = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + IDW'(1);
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Address relocation into the shared map, active only while running.
    always_comb begin
        raddr_c = '0;
        waddr_c = '0;
        wen_c   = 1'b0;
        if (state_q == S_RUN) begin
            raddr_c = eng_raddr_i + (eng_is_weight_i ? wbase_q : fbase_q);
            waddr_c = eng_waddr_i + obase_q;
            wen_c   = eng_wen_i;
        end
    end

    // Outputs forced low while reset is asserted so an interrupted job is silent.
    always_comb begin
        req_ready_o  = ready_c & {NREQ{rstn_i}};
        eng_start_o  = start_c & rstn_i;
        eng_abort_o  = abort_c & rstn_i;
        resp_valid_o = resp_c & rstn_i;
        resp_id_o    = (resp_c & rstn_i) ? id_q : '0;
        resp_err_o   = resp_c & rstn_i & err_q;
        mem_raddr_o  = raddr_c & {AW{rstn_i}};
        mem_waddr_o  = waddr_c & {AW{rstn_i}};
        mem_wen_o    = wen_c & rstn_i;
        busy_o       = (state_q != S_IDLE) & rstn_i;
    end

endmodule

// File: tb/tb_conv2d_sched.sv
// tb_conv2d_sched: scoreboard bench for the conv2d job scheduler.
module tb_conv2d_sched;

    localparam int NREQ = 2;
    localparam int AW   = 16;
    localparam int TO   = 16;

    logic                 clk = 1'b0;
    logic                 rstn_i;
    logic [NREQ-1:0]      req_valid_i;
    logic [NREQ-1:0]      req_ready_o;
    logic [NREQ*AW-1:0]   req_wbase_i, req_fbase_i, req_obase_i;
    logic                 eng_start_o, eng_abort_o, eng_done_i;
    logic [AW-1:0]        eng_raddr_i, eng_waddr_i;
    logic                 eng_is_weight_i, eng_wen_i;
    logic [AW-1:0]        mem_raddr_o, mem_waddr_o;
    logic                 mem_wen_o, resp_valid_o, resp_err_o, busy_o;
    logic [0:0]           resp_id_o;

    always #5 clk = ~clk;

    conv2d_sched #(.NREQ(NREQ), .AW(AW), .TIMEOUT(TO)) dut (
        .clk_i(clk), .rstn_i(rstn_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_wbase_i(req_wbase_i), .req_fbase_i(req_fbase_i), .req_obase_i(req_obase_i),
        .eng_start_o(eng_start_o), .eng_abort_o(eng_abort_o), .eng_done_i(eng_done_i),
        .eng_raddr_i(eng_raddr_i), .eng_is_weight_i(eng_is_weight_i),
        .eng_waddr_i(eng_waddr_i), .eng_wen_i(eng_wen_i),
        .mem_raddr_o(mem_raddr_o), .mem_waddr_o(mem_waddr_o), .mem_wen_o(mem_wen_o),
        .resp_valid_o(resp_valid_o), .resp_id_o(resp_id_o), .resp_err_o(resp_err_o),
        .busy_o(busy_o)
    );

    typedef struct packed {
        logic [0:0] id;
        logic       err;
    } resp_t;

    resp_t         exp_q[$];
    resp_t         mon_e;
    int            total = 0;
    int            bad   = 0;
    int            rr_m  = 0;
    logic [AW-1:0] wb [NREQ];
    logic [AW-1:0] fb [NREQ];
    logic [AW-1:0] ob [NREQ];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive_desc();
        req_wbase_i = {wb[1], wb[0]};
        req_fbase_i = {fb[1], fb[0]};
        req_obase_i = {ob[1], ob[0]};
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, 32'(req_ready_o), 0);
        chk({tag, "_start"}, 32'(eng_start_o), 0);
        chk({tag, "_abort"}, 32'(eng_abort_o), 0);
        chk({tag, "_resp"},  32'(resp_valid_o), 0);
        chk({tag, "_raddr"}, 32'(mem_raddr_o), 0);
        chk({tag, "_waddr"}, 32'(mem_waddr_o), 0);
        chk({tag, "_wen"},   32'(mem_wen_o), 0);
        chk({tag, "_busy"},  32'(busy_o), 0);
    endtask

    // Monitor: every response pulse is matched against the oldest expected entry.
    always @(negedge clk) begin
        if (resp_valid_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL resp_unexpected: got id=%0d err=%0d want no response",
                         resp_id_o, resp_err_o);
            end else begin
                mon_e = exp_q.pop_front();
                chk("resp_id",  32'(resp_id_o),  32'(mon_e.id));
                chk("resp_err", 32'(resp_err_o), 32'(mon_e.err));
            end
        end
    end

    // One full job: grant, launch, run (with engine model), response.
    // eng_cyc: RUN cycle on which done is pulsed (0 or >TO means never).
    // rst_at: RUN cycle on which reset is asserted (0 means never).
    task automatic run_job(input logic [1:0] mask, input int eng_cyc,
                           input bit directed, input int rst_at);
        int            g;
        int            c;
        bit            fin;
        logic [AW-1:0] gw, gf, go, er, ew;

        @(posedge clk); #1;
        req_valid_i = mask;
        drive_desc();
        #1;
        g = 0;
        for (int i = 0; i < NREQ; i++) begin
            c = (rr_m + i) % NREQ;
            if (mask[c]) begin
                g = c;
                break;
            end
        end
        chk("ready_grant", 32'(req_ready_o), 32'(1 << g));
        chk("busy_idle",   32'(busy_o), 0);
        chk("start_idle",  32'(eng_start_o), 0);
        gw = wb[g]; gf = fb[g]; go = ob[g];

        // Launch cycle: descriptor of the granted requester is scrambled.
        @(posedge clk); #1;
        req_valid_i[g] = 1'b0;
        wb[g] = AW'($urandom); fb[g] = AW'($urandom); ob[g] = AW'($urandom);
        drive_desc();
        eng_raddr_i = AW'($urandom); eng_waddr_i = AW'($urandom);
        eng_is_weight_i = 1'b1; eng_wen_i = 1'b1;
        #1;
        chk("start_launch", 32'(eng_start_o), 1);
        chk("ready_launch", 32'(req_ready_o), 0);
        chk("raddr_launch", 32'(mem_raddr_o), 0);
        chk("wen_launch",   32'(mem_wen_o), 0);
        chk("busy_launch",  32'(busy_o), 1);

        fin = 1'b0;
        for (int k = 1; k <= TO && !fin; k++) begin
            @(posedge clk); #1;
            if (directed) begin
                case ((k - 1) % 4)
                    0: begin eng_raddr_i = 16'h0005; eng_is_weight_i = 1'b1;
                             eng_waddr_i = 16'h0003; eng_wen_i = 1'b1; end
                    1: begin eng_raddr_i = 16'h0005; eng_is_weight_i = 1'b0;
                             eng_waddr_i = 16'h0003; eng_wen_i = 1'b0; end
                    2: begin eng_raddr_i = 16'h0020; eng_is_weight_i = 1'b0;
                             eng_waddr_i = 16'h0007; eng_wen_i = 1'b1; end
                    default: begin eng_raddr_i = 16'hFFFF; eng_is_weight_i = 1'b1;
                             eng_waddr_i = 16'hFFFF; eng_wen_i = 1'b1; end
                endcase
            end else begin
                eng_raddr_i = AW'($urandom); eng_waddr_i = AW'($urandom);
                eng_is_weight_i = 1'($urandom); eng_wen_i = 1'($urandom);
            end
            eng_done_i = (k == eng_cyc);
            if (k == rst_at) begin
                rstn_i = 1'b0;
                eng_done_i = 1'b0;
                req_valid_i = '0;
                #1;
                chk_all_zero("rst_during");
                @(posedge clk); #1;
                chk_all_zero("rst_after");
                rstn_i = 1'b1;
                #1;
                chk_all_zero("rst_release");
                rr_m = 0;
                return;
            end
            #1;
            er = eng_raddr_i + (eng_is_weight_i ? gw : gf);
            ew = eng_waddr_i + go;
            chk("mem_raddr", 32'(mem_raddr_o), 32'(er));
            chk("mem_waddr", 32'(mem_waddr_o), 32'(ew));
            chk("mem_wen",   32'(mem_wen_o),   32'(eng_wen_i));
            chk("abort_run", 32'(eng_abort_o), 32'((k == TO) && (k != eng_cyc)));
            chk("ready_run", 32'(req_ready_o), 0);
            chk("start_run", 32'(eng_start_o), 0);
            chk("busy_run",  32'(busy_o), 1);
            if (k == eng_cyc || k == TO) begin
                exp_q.push_back('{id: 1'(g), err: (k != eng_cyc)});
                fin = 1'b1;
            end
        end

        // Response cycle: engine activity must not leak through.
        @(posedge clk); #1;
        eng_done_i = 1'b0;
        eng_raddr_i = AW'($urandom); eng_wen_i = 1'b1;
        #1;
        chk("raddr_resp", 32'(mem_raddr_o), 0);
        chk("wen_resp",   32'(mem_wen_o), 0);
        chk("ready_resp", 32'(req_ready_o), 0);
        chk("abort_resp", 32'(eng_abort_o), 0);
        chk("busy_resp",  32'(busy_o), 1);
        rr_m = (g + 1) % NREQ;
    endtask

    initial begin
        int ec;
        logic [1:0] m;
        rstn_i = 1'b0;
        req_valid_i = '0;
        eng_done_i = 1'b0; eng_raddr_i = '0; eng_waddr_i = '0;
        eng_is_weight_i = 1'b0; eng_wen_i = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            wb[i] = '0; fb[i] = '0; ob[i] = '0;
        end
        drive_desc();
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rstn_i = 1'b1;
        #1;
        chk_all_zero("post_reset");

        // Single directed job on requester 0.
        wb[0] = 16'h0100; fb[0] = 16'h0400; ob[0] = 16'h0800;
        run_job(2'b01, 4, 1'b1, 0);
        // Requester 1 alone, so rr returns to 0.
        wb[1] = AW'($urandom); fb[1] = AW'($urandom); ob[1] = AW'($urandom);
        run_job(2'b10, 2, 1'b0, 0);

        // Fairness: both valid for four jobs.
        for (int j = 0; j < 4; j++) begin
            for (int i = 0; i < NREQ; i++) begin
                wb[i] = AW'($urandom); fb[i] = AW'($urandom); ob[i] = AW'($urandom);
            end
            run_job(2'b11, int'($urandom_range(1, 15)), 1'b0, 0);
        end

        // Timeout, then done coinciding with timeout.
        run_job(2'b01, 0, 1'b0, 0);
        run_job(2'b11, TO, 1'b0, 0);

        // Address wrap on the feature base.
        fb[1] = 16'hFFF0; wb[1] = 16'hFF00; ob[1] = 16'hFFFA;
        run_job(2'b10, 5, 1'b1, 0);

        // Stray engine done while idle.
        @(posedge clk); #1;
        req_valid_i = '0;
        eng_done_i = 1'b1;
        #1;
        chk("stray_busy", 32'(busy_o), 0);
        @(posedge clk); #1;
        eng_done_i = 1'b0;
        #1;
        chk("stray_resp",  32'(resp_valid_o), 0);
        chk("stray_busy2", 32'(busy_o), 0);
        chk("stray_start", 32'(eng_start_o), 0);

        // Reset mid-run, then a fresh contested request restarts at requester 0.
        run_job(2'b01, 3, 1'b0, 0);
        run_job(2'b10, 0, 1'b0, 3);
        run_job(2'b11, 2, 1'b0, 0);

        // Randomized mix, including never-done jobs.
        for (int j = 0; j < 10; j++) begin
            m = 2'($urandom_range(1, 3));
            ec = int'($urandom_range(1, 17));
            for (int i = 0; i < NREQ; i++) begin
                wb[i] = AW'($urandom); fb[i] = AW'($urandom); ob[i] = AW'($urandom);
            end
            run_job(m, ec, 1'b0, 0);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("pending_resp", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
